// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Brief    : Shared op encodings, FSM state type and op-decoding predicates
//            for the iterative multiply/divide unit.
// Revision : 1.0
// ============================================================================
package muldiv_pkg;

   // RISC-V funct3 encodings for the M extension
   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   function automatic logic is_signed_a(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
   endfunction

   function automatic logic is_signed_b(input logic [2:0] op);
      return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
   endfunction

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_addsub.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_addsub
// Brief    : Combinational W-bit adder/subtractor with carry-out; cout=1 on
//            subtract means no borrow (a >= b unsigned).
// Revision : 1.0
// ============================================================================
module muldiv_addsub
   import muldiv_pkg::*;
#(
   parameter int W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic [W-1:0] w_b_eff;

   always_comb begin
      w_b_eff     = sub ? ~b : b;
      {cout, sum} = {1'b0, a} + {1'b0, w_b_eff} + {{W{1'b0}}, sub};
   end

endmodule : muldiv_addsub
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Brief    : Iterative radix-2 RV32M/RV64M multiply/divide unit with
//            valid/ready handshake, kill and ISA-defined boundary results.
//            Build option: MULDIV_EARLY_OUT_EN (trivial operands skip CALC).
// Revision : 1.0
// ============================================================================
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      in_op,
   input  logic [XLEN-1:0] in_a,
   input  logic [XLEN-1:0] in_b,
   input  logic            kill,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_result,
   output logic            out_divzero
);

   localparam int                 c_cnt_w    = $clog2(XLEN);
   localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(XLEN - 1);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

   state_t              r_state;
   state_t              w_next_state;
   logic [c_cnt_w-1:0]  r_cnt;
   logic [2:0]          r_op;
   logic                r_neg_res;
   logic                r_neg_rem;
   logic                r_divzero;
   logic [XLEN-1:0]     r_opnd;
   logic [2*XLEN-1:0]   r_prod;
   logic                r_out_valid;
   logic [XLEN-1:0]     r_out_result;
   logic                r_out_divzero;

   logic                w_accept;
   logic                w_sign_a;
   logic                w_sign_b;
   logic                w_b_zero;
   logic                w_early;
   logic [XLEN-1:0]     w_a_mag;
   logic [XLEN-1:0]     w_b_mag;
   logic [2*XLEN-1:0]   w_load_prod;

   logic [XLEN-1:0]     w_hi;
   logic [XLEN-1:0]     w_lo;
   logic                w_as_sub;
   logic [XLEN:0]       w_as_a;
   logic [XLEN:0]       w_as_b;
   logic [XLEN:0]       w_as_sum;
   logic                w_as_cout;
   logic [2*XLEN-1:0]   w_step;

   logic [2*XLEN-1:0]   w_prod_fix;
   logic [XLEN-1:0]     w_quo;
   logic [XLEN-1:0]     w_rem;
   logic [XLEN-1:0]     w_fix_result;

   assign w_accept    = (r_state == ST_IDLE) && in_valid && !kill;
   assign in_ready    = (r_state == ST_IDLE);
   assign out_valid   = r_out_valid;
   assign out_result  = r_out_result;
   assign out_divzero = r_out_divzero;

   // Operand preparation: signed operands become magnitudes, signs remembered
   always_comb begin
      w_sign_a    = is_signed_a(in_op) & in_a[XLEN-1];
      w_sign_b    = is_signed_b(in_op) & in_b[XLEN-1];
      w_a_mag     = w_sign_a ? -in_a : in_a;
      w_b_mag     = w_sign_b ? -in_b : in_b;
      w_b_zero    = (in_b == '0);
      w_load_prod = is_div(in_op) ? {{XLEN{1'b0}}, w_a_mag} : {{XLEN{1'b0}}, w_b_mag};
      w_early     = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
      if (is_div(in_op)) begin
         if (w_b_zero) begin
            // Remainder half holds |a| so FIX re-signs it back to in_a
            w_early     = 1'b1;
            w_load_prod = {w_a_mag, {XLEN{1'b0}}};
         end else if (is_signed_a(in_op) && (in_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (in_b == '1)) begin
            w_early = 1'b1;
         end
      end else if ((in_a == '0) || w_b_zero) begin
         w_early     = 1'b1;
         w_load_prod = '0;
      end
`endif
   end

   // One radix-2 step: shift-add for multiply, restoring subtract for divide
   assign w_hi     = r_prod[2*XLEN-1:XLEN];
   assign w_lo     = r_prod[XLEN-1:0];
   assign w_as_sub = is_div(r_op);

   always_comb begin
      w_as_a = w_as_sub ? {w_hi, w_lo[XLEN-1]} : {1'b0, w_hi};
      w_as_b = (w_as_sub || w_lo[0]) ? {1'b0, r_opnd} : '0;
      if (!w_as_sub) begin
         w_step = {w_as_sum, w_lo[XLEN-1:1]};
      end else if (w_as_cout) begin
         w_step = {w_as_sum[XLEN-1:0], w_lo[XLEN-2:0], 1'b1};
      end else begin
         w_step = {w_as_a[XLEN-1:0], w_lo[XLEN-2:0], 1'b0};
      end
   end

   muldiv_addsub #(
      .W    (XLEN + 1)
   ) u_addsub (
      .a    (w_as_a),
      .b    (w_as_b),
      .sub  (w_as_sub),
      .sum  (w_as_sum),
      .cout (w_as_cout)
   );

   // Sign correction and result selection; quotient of x/0 is forced to all ones
   always_comb begin
      w_prod_fix = r_neg_res ? -r_prod : r_prod;
      w_quo      = r_divzero ? '1 : (r_neg_res ? -w_lo : w_lo);
      w_rem      = r_neg_rem ? -w_hi : w_hi;
      case (r_op)
         OP_MUL:                       w_fix_result = w_prod_fix[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: w_fix_result = w_prod_fix[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              w_fix_result = w_quo;
         default:                      w_fix_result = w_rem;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (kill) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (w_accept) w_next_state = w_early ? ST_FIX : ST_CALC;
            ST_CALC: if (r_cnt == c_last_cnt) w_next_state = ST_FIX;
            ST_FIX:  w_next_state = ST_DONE;
            ST_DONE: if (out_ready) w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt         <= '0;
         r_op          <= OP_MUL;
         r_neg_res     <= 1'b0;
         r_neg_rem     <= 1'b0;
         r_divzero     <= 1'b0;
         r_opnd        <= '0;
         r_prod        <= '0;
         r_out_valid   <= 1'b0;
         r_out_result  <= '0;
         r_out_divzero <= 1'b0;
      end else if (kill) begin
         r_out_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_op      <= in_op;
                  r_neg_res <= w_sign_a ^ w_sign_b;
                  r_neg_rem <= w_sign_a;
                  r_divzero <= is_div(in_op) & w_b_zero;
                  r_opnd    <= is_div(in_op) ? w_b_mag : w_a_mag;
                  r_prod    <= w_load_prod;
                  r_cnt     <= '0;
               end
            end
            ST_CALC: begin
               r_prod <= w_step;
               r_cnt  <= r_cnt + c_cnt_one;
            end
            ST_FIX: begin
               r_out_valid   <= 1'b1;
               r_out_result  <= w_fix_result;
               r_out_divzero <= r_divzero;
            end
            default: begin
               if (out_ready) r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Brief    : Directed scoreboard bench for muldiv_unit (XLEN=32): arithmetic,
//            boundary results, latency, result hold, kill and async reset.
// Revision : 1.0
// ============================================================================
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 200;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      in_op;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_result;
   logic            out_divzero;

   muldiv_unit #(.XLEN(XLEN)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_op       (in_op),
      .in_a        (in_a),
      .in_b        (in_b),
      .kill        (kill),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_divzero (out_divzero)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [XLEN-1:0] exp_res_q[$];
   logic            exp_dz_q[$];
   int              exp_lat_q[$];
   string           tag_q[$];

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Edges from the accepting edge to the edge after which out_valid is seen;
   // XLEN+1 edges places out_valid in the (XLEN+2)th cycle after acceptance.
   function automatic int exp_latency(input logic [2:0] op, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      bit special;
      if (op[2]) special = (b == 0) || (((op == OP_DIV) || (op == OP_REM)) &&
                                         (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF));
      else       special = (a == 0) || (b == 0);
      return special ? 1 : XLEN + 1;
`else
      return XLEN + 1;
`endif
   endfunction

   // Caller is at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input bit track, input logic [XLEN-1:0] er, input logic edz, input string tg);
      if (track) begin
         exp_res_q.push_back(er);
         exp_dz_q.push_back(edz);
         exp_lat_q.push_back(exp_latency(op, a, b));
         tag_q.push_back(tg);
      end
      in_op    = op;
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic collect(output logic [XLEN-1:0] er);
      int    lat;
      bit    seen;
      logic  edz;
      int    el;
      string tg;
      er  = exp_res_q.pop_front();
      edz = exp_dz_q.pop_front();
      el  = exp_lat_q.pop_front();
      tg  = tag_q.pop_front();
      lat  = 0;
      seen = 1'b0;
      while (!seen && (lat < TIMEOUT)) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid === 1'b1) seen = 1'b1;
      end
      check({tg, " out_valid"}, 64'(seen), 64'(1));
      check({tg, " latency"}, 64'(lat), 64'(el));
      check({tg, " result"}, 64'(out_result), 64'(er));
      check({tg, " divzero"}, 64'(out_divzero), 64'(edz));
   endtask

   task automatic release_result(input string tg);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      check({tg, " valid dropped"}, 64'(out_valid), 64'(0));
      check({tg, " in_ready back"}, 64'(in_ready), 64'(1));
   endtask

   task automatic run_op(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] er, input logic edz, input string tg);
      logic [XLEN-1:0] got_exp;
      send(op, a, b, 1'b1, er, edz, tg);
      collect(got_exp);
      release_result(tg);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [XLEN-1:0] held;
      bit              saw;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      kill      = 1'b0;
      out_ready = 1'b0;
      in_op     = '0;
      in_a      = '0;
      in_b      = '0;
      repeat (3) @(negedge clk);
      check("reset in_ready",    64'(in_ready),    64'(1));
      check("reset out_valid",   64'(out_valid),   64'(0));
      check("reset out_result",  64'(out_result),  64'(0));
      check("reset out_divzero", 64'(out_divzero), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      run_op(OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, "mul ff*ff");
      run_op(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, "mulhu ff*ff");
      run_op(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, "mulh min*min");
      run_op(OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, "mulhsu -1*2");
      run_op(OP_MUL,    32'h0000_0000, 32'h0000_0005, 32'h0000_0000, 1'b0, "mul 0*5");
      run_op(OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0, "div 7/-2");
      run_op(OP_REM,    32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "rem 7/-2");
      run_op(OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, "div -7/2");
      run_op(OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, "rem -7/2");
      run_op(OP_DIVU,   32'd7,         32'd2,         32'd3,         1'b0, "divu 7/2");
      run_op(OP_REMU,   32'd7,         32'd2,         32'd1,         1'b0, "remu 7/2");
      run_op(OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1'b1, "div 5/0");
      run_op(OP_REM,    32'd5,         32'd0,         32'd5,         1'b1, "rem 5/0");
      run_op(OP_DIVU,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1'b1, "divu x/0");
      run_op(OP_REM,    32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1'b1, "rem -5/0");
      run_op(OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, "div ovf");
      run_op(OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, "rem ovf");

      // Result must hold while the consumer stalls
      send(OP_DIV, 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 1'b0, "hold div 100/-7");
      collect(held);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold out_valid", 64'(out_valid),  64'(1));
         check("hold out_result", 64'(out_result), 64'(held));
         check("hold in_ready",  64'(in_ready),   64'(0));
      end
      release_result("hold");
      run_op(OP_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 1'b0, "after hold rem 100/-7");

      // kill in IDLE together with a request: nothing accepted
      in_op    = OP_MUL;
      in_a     = 32'd3;
      in_b     = 32'd4;
      in_valid = 1'b1;
      kill     = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      kill     = 1'b0;
      check("idle kill in_ready", 64'(in_ready), 64'(1));

      // kill during the fifth CALC cycle
      send(OP_DIVU, 32'd1000, 32'd3, 1'b0, '0, 1'b0, "killed");
      repeat (4) @(posedge clk);
      @(negedge clk);
      kill = 1'b1;
      @(posedge clk);
      @(negedge clk);
      kill = 1'b0;
      check("kill in_ready", 64'(in_ready), 64'(1));
      saw = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (out_valid !== 1'b0) saw = 1'b1;
      end
      check("kill no out_valid", 64'(saw), 64'(0));
      run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, "divu 100/7");

      // Asynchronous reset in the middle of CALC
      send(OP_MUL, 32'd5, 32'd6, 1'b0, '0, 1'b0, "reset victim");
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset in_ready",    64'(in_ready),    64'(1));
      check("midreset out_valid",   64'(out_valid),   64'(0));
      check("midreset out_result",  64'(out_result),  64'(0));
      check("midreset out_divzero", 64'(out_divzero), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op(OP_MUL, 32'd3, 32'd4, 32'd12, 1'b0, "mul 3*4 after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_muldiv_unit
`default_nettype wire

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative, parametrised integer multiply/divide unit for the RV32M/RV64M instruction group, sitting beside the single-cycle ALU in the execute stage. It accepts one operation at a time over a valid/ready handshake, computes for a fixed number of cycles using a shared adder/subtractor, applies sign correction, and holds the result until the consumer takes it. A kill input aborts an in-flight operation on pipeline flush.

## Interface
- XLEN, 32: operand/result width; must be 32 or 64.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_op  in  3  RISC-V funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- in_a  in  XLEN  rs1 (multiplicand/dividend).
- in_b  in  XLEN  rs2 (multiplier/divisor).
- kill  in  1  abort current operation; dominates all other inputs except reset.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  XLEN  result.
- out_divzero  out  1  flag: divide op with in_b == 0 (informational; result is still the ISA-defined value).

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid && !kill: latch op, record operand signs, convert signed operands to magnitudes (MULH: both signed; MULHSU: a signed only; DIV/REM: both signed), clear counter, go CALC.
- CALC: one radix-2 step per cycle, XLEN steps, counter 0..XLEN-1.
  - Multiply: 2*XLEN-bit product register, shift-add, low half initialised with multiplier magnitude.
  - Divide: restoring; XLEN+1-bit partial remainder, subtract divisor, keep if non-negative, shift quotient bit in.
  - Counter == XLEN-1 -> FIX.
- FIX: negate product if operand signs differ (signed cases); quotient negated if signs differ; remainder takes dividend sign. Select low half (MUL) or high half (MULH*), quotient or remainder. Go DONE.
- DONE: out_valid=1, out_result/out_divzero stable. On out_ready -> IDLE. New request is not accepted in the same cycle (in_ready only in IDLE).
- Boundary rules (ISA-mandated, produced by the normal datapath plus FIX override):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = in_a.
  - Signed overflow (in_a = most negative, in_b = -1): DIV = in_a; REM = 0.
- kill in any state: next state IDLE, out_valid drops next cycle, result discarded. kill in IDLE with in_valid: request not accepted.
- Reset: state IDLE, counter 0, out_valid 0, out_result 0, out_divzero 0, in_ready 1 after release. Reset mid-operation discards it.

## Timing
- Acceptance at edge E0 (in_valid && in_ready). CALC occupies XLEN cycles, FIX one, so out_valid rises XLEN+2 cycles after E0 (34 for XLEN=32) without early-out.
- out_valid holds indefinitely while out_ready=0; out_result must not change.
- Throughput: one op per XLEN+3 cycles with out_ready tied high.
- Outputs are registered; no combinational path from in_* to out_*.

## Configuration
- MULDIV_EARLY_OUT_EN defined: in IDLE on acceptance, divide-by-zero, signed-overflow, and multiply with either operand zero bypass CALC and go directly to FIX with the override value; out_valid at E0+2.
- Undefined: every op takes full XLEN+2 latency; results are bit-identical to the defined build.

## Structure
- muldiv_pkg: op encoding localparams (OP_MUL..OP_REMU), state enum, helper predicates is_div/is_signed_a/is_signed_b.
- Sub-module muldiv_addsub: XLEN+1-bit add/subtract with carry-out, shared by multiply and divide steps; combinational.
- Top holds FSM, counter, operand/product registers, FIX logic.

## Test plan
- MUL/MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001 / 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF; out_valid exactly 34 cycles after accept.
- DIV 7 / -2 -> 0xFFFFFFFD, REM -> 1; DIVU 7 / 2 -> 3, REMU -> 1.
- DIV 5 / 0 -> 0xFFFFFFFF, out_divzero=1; REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0 (latency 2 with MULDIV_EARLY_OUT_EN, 34 without).
- out_ready low 10 cycles in DONE -> out_valid and out_result held; in_ready stays 0; accepted next op after out_ready starts fresh.
- kill asserted at CALC cycle 5 -> IDLE next cycle, no out_valid; following DIVU 100/7 returns 14 normally.
- rst_n asserted mid-CALC -> all outputs at reset values immediately; after release, MUL 3 x 4 -> 12.
